// File: rtl/dvp_rgb565_tx_if.sv
// AXI-Stream pixel channel feeding RGB565 beats into the DVP transmitter.
interface dvp_rgb565_tx_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        tready;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/dvp_rgb565_tx.sv
// RGB565 AXI-Stream to 8-bit DVP serialiser with full frame timing generation.
// Frame-side outputs follow the state register by one cycle; the pixel path has 1-cycle latency.
module dvp_rgb565_tx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10
) (
    input  logic                  pclk,
    input  logic                  rstn,
    input  logic                  enable,
    dvp_rgb565_tx_if.slave        s_axis,
    output logic [7:0]            dout,
    output logic                  href,
    output logic                  vsync,
    output logic                  underrun,
    output logic                  line_err,
    output logic                  busy
);
    localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned V_MAX_A  = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
    localparam int unsigned V_MAX_B  = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int unsigned V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int unsigned HW       = $clog2(LINE_LEN + 1);
    localparam int unsigned VW       = $clog2(V_MAX + 1);
    localparam int unsigned PW       = HW - 1;

    localparam logic [HW-1:0] H_LAST   = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] ACT_LAST = HW'(2 * H_ACTIVE - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES - 1);
    localparam logic [VW-1:0] VB_LAST  = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VF_LAST  = VW'(V_FRONT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StHblank,
        StVfront
    } state_e;

    state_e        state_q;
    logic [HW-1:0] hcnt_q;
    logic [VW-1:0] vcnt_q;
    logic [7:0]    lo_q;
    logic          live_q;

    logic [PW-1:0] pix;
    logic          line_end;
    logic [VW-1:0] blank_last;
    state_e        blank_next;

    assign pix      = hcnt_q[HW-1:1];
    assign line_end = (hcnt_q == H_LAST);

    // Non-SOF beats are flushed in IDLE; during active video a slot opens on every even byte.
    assign s_axis.tready = live_q &
                           (((state_q == StIdle) & enable & ~s_axis.tuser) |
                            ((state_q == StActive) & ~hcnt_q[0]));

    always_comb begin
        blank_last = VS_LAST;
        blank_next = StVback;
        unique case (state_q)
            StVback: begin
                blank_last = VB_LAST;
                blank_next = StActive;
            end
            StVfront: begin
                blank_last = VF_LAST;
                blank_next = StIdle;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            lo_q     <= '0;
            live_q   <= 1'b0;
            dout     <= '0;
            href     <= 1'b0;
            vsync    <= 1'b0;
            underrun <= 1'b0;
            line_err <= 1'b0;
            busy     <= 1'b0;
        end else begin
            live_q <= 1'b1;
            vsync  <= (state_q == StVsync);
            busy   <= (state_q != StIdle);
            href   <= 1'b0;
            dout   <= '0;
            case (state_q)
                StIdle: begin
                    if (live_q && enable && s_axis.tvalid && s_axis.tuser) begin
                        state_q <= StVsync;
                        hcnt_q  <= '0;
                        vcnt_q  <= '0;
                    end
                end
                StVsync, StVback, StVfront: begin
                    if (line_end) begin
                        hcnt_q <= '0;
                        if (vcnt_q == blank_last) begin
                            vcnt_q  <= '0;
                            state_q <= blank_next;
                        end else begin
                            vcnt_q <= vcnt_q + 1'b1;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                StActive: begin
                    href <= 1'b1;
                    if (!hcnt_q[0]) begin
                        if (s_axis.tvalid) begin
                            dout <= s_axis.tdata[15:8];
                            lo_q <= s_axis.tdata[7:0];
                            if ((s_axis.tlast != (pix == PIX_LAST)) ||
                                (s_axis.tuser && !(vcnt_q == '0 && pix == '0))) begin
                                line_err <= 1'b1;
                            end
                        end else begin
                            // Missing pixel: blank it out but keep line timing intact.
                            lo_q     <= '0;
                            underrun <= 1'b1;
                        end
                    end else begin
                        dout <= lo_q;
                    end
                    hcnt_q <= hcnt_q + 1'b1;
                    if (hcnt_q == ACT_LAST) begin
                        state_q <= StHblank;
                    end
                end
                StHblank: begin
                    if (line_end) begin
                        hcnt_q <= '0;
                        if (vcnt_q == VA_LAST) begin
                            vcnt_q  <= '0;
                            state_q <= StVfront;
                        end else begin
                            vcnt_q  <= vcnt_q + 1'b1;
                            state_q <= StActive;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// Randomised self-checking bench for dvp_rgb565_tx against a frame-level timeline model.
module tb_dvp_rgb565_tx;
    localparam int H     = 4;
    localparam int VA    = 2;
    localparam int HB    = 3;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int LP    = 2 * H + HB;
    localparam int TOTAL = LP * (VS + VB + VA + VF);

    typedef struct {
        logic [15:0] data;
        bit          last;
        bit          user;
        bit          gap;
    } beat_t;

    logic       pclk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] dout;
    logic       href, vsync, underrun, line_err, busy;

    dvp_rgb565_tx_if s_if ();

    dvp_rgb565_tx #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (VA),
        .H_BLANK    (HB),
        .VSYNC_LINES(VS),
        .V_BACK     (VB),
        .V_FRONT    (VF)
    ) dut (
        .pclk    (pclk),
        .rstn    (rstn),
        .enable  (enable),
        .s_axis  (s_if),
        .dout    (dout),
        .href    (href),
        .vsync   (vsync),
        .underrun(underrun),
        .line_err(line_err),
        .busy    (busy)
    );

    always #5 pclk = ~pclk;

    beat_t drv_q[$];
    beat_t frame_px[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    n_acc = 0;
    bit    exp_under = 0;
    bit    exp_lerr = 0;

    // Expected frame-side outputs t cycles after vsync first rises.
    function automatic void exp_at(input int t, output logic v, output logic h,
                                   output logic [7:0] d);
        int a0, rel, b, p;
        a0 = LP * (VS + VB);
        v  = (t < LP * VS);
        h  = 1'b0;
        d  = 8'h00;
        if (t >= a0 && t < a0 + VA * LP) begin
            rel = t - a0;
            b   = rel % LP;
            if (b < 2 * H) begin
                h = 1'b1;
                p = (rel / LP) * H + b / 2;
                if (!frame_px[p].gap) d = (b % 2 == 0) ? frame_px[p].data[15:8] : frame_px[p].data[7:0];
            end
        end
    endfunction

    task automatic fill_std();
        beat_t b;
        logic [15:0] pat [4];
        pat[0] = 16'h1234; pat[1] = 16'h5678; pat[2] = 16'h9ABC; pat[3] = 16'hDEF0;
        frame_px.delete();
        for (int i = 0; i < VA * H; i++) begin
            b.data = pat[i % 4];
            b.last = ((i % H) == H - 1);
            b.user = (i == 0);
            b.gap  = 1'b0;
            frame_px.push_back(b);
        end
    endtask

    task automatic fill_random();
        beat_t b;
        frame_px.delete();
        for (int i = 0; i < VA * H; i++) begin
            b.data = 16'($urandom);
            b.last = ((i % H) == H - 1) ^ ($urandom_range(0, 9) == 0);
            b.user = (i == 0) || ($urandom_range(0, 19) == 0);
            b.gap  = (i != 0) && ($urandom_range(0, 7) == 0);
            frame_px.push_back(b);
        end
    endtask

    task automatic drive_beats();
        int guard = 0;
        bit fire;
        n_acc = 0;
        while (drv_q.size() > 0 && guard < 2000) begin
            s_if.tdata  = drv_q[0].data;
            s_if.tvalid = !drv_q[0].gap;
            s_if.tlast  = drv_q[0].last;
            s_if.tuser  = drv_q[0].user;
            #1;
            fire = s_if.tready;
            @(negedge pclk);
            if (fire && drv_q.size() > 0) begin
                drv_q.delete(0);
                n_acc++;
            end
            guard++;
        end
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic check_frame(input int abort_at, input bit drop_en);
        int   w = 0;
        logic ev, eh;
        logic [7:0] ed;
        while (vsync !== 1'b1 && w < 300) begin
            @(negedge pclk);
            w++;
        end
        n_cmp++;
        if (vsync !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_start: vsync got %b want 1 within 300 cycles", vsync);
            drv_q.delete();
            return;
        end
        for (int t = 0; t < TOTAL; t++) begin
            if (t == abort_at) begin
                #2 rstn = 1'b0;
                drv_q.delete();
                #1;
                n_cmp++;
                if ({dout, href, vsync, s_if.tready, busy} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL async_reset: dout/href/vsync/tready/busy got %h/%b/%b/%b/%b want 00/0/0/0/0",
                             dout, href, vsync, s_if.tready, busy);
                end
                repeat (2) @(negedge pclk);
                rstn      = 1'b1;
                exp_under = 1'b0;
                exp_lerr  = 1'b0;
                repeat (2) @(negedge pclk);
                n_cmp++;
                if ({busy, vsync, href, underrun, line_err} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL post_reset_idle: busy/vsync/href/underrun/line_err got %b%b%b%b%b want 00000",
                             busy, vsync, href, underrun, line_err);
                end
                return;
            end
            if (drop_en && t == LP * VS + 2) enable = 1'b0;
            exp_at(t, ev, eh, ed);
            n_cmp++;
            if ({vsync, href, dout, busy} !== {ev, eh, ed, 1'b1}) begin
                n_fail++;
                $display("FAIL frame t=%0d: vsync/href/dout/busy got %b/%b/%h/%b want %b/%b/%h/1",
                         t, vsync, href, dout, busy, ev, eh, ed);
            end
            @(negedge pclk);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: busy got %b want 0", busy);
        end
    endtask

    task automatic run_frame(input int prefix, input int abort_at, input bit drop_en);
        beat_t b;
        enable = 1'b1;
        drv_q.delete();
        for (int i = 0; i < prefix; i++) begin
            b.data = 16'($urandom);
            b.last = $urandom_range(0, 1) == 1;
            b.user = 1'b0;
            b.gap  = 1'b0;
            drv_q.push_back(b);
        end
        foreach (frame_px[i]) drv_q.push_back(frame_px[i]);
        if (abort_at < 0) begin
            foreach (frame_px[i]) begin
                if (frame_px[i].gap) exp_under = 1'b1;
                else if ((frame_px[i].last != ((i % H) == H - 1)) || (frame_px[i].user && i != 0))
                    exp_lerr = 1'b1;
            end
        end
        fork
            drive_beats();
            check_frame(abort_at, drop_en);
        join
        if (abort_at < 0) begin
            n_cmp++;
            if (n_acc != prefix + VA * H) begin
                n_fail++;
                $display("FAIL beats_accepted: got %0d want %0d", n_acc, prefix + VA * H);
            end
            n_cmp++;
            if ({underrun, line_err} !== {exp_under, exp_lerr}) begin
                n_fail++;
                $display("FAIL sticky_flags: underrun/line_err got %b/%b want %b/%b",
                         underrun, line_err, exp_under, exp_lerr);
            end
        end
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        enable      = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (2) @(negedge pclk);
        rstn      = 1'b1;
        exp_under = 1'b0;
        exp_lerr  = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        enable      = 1'b1;
        s_if.tdata  = 16'hFFFF;
        s_if.tvalid = 1'b1;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (2) @(negedge pclk);
        n_cmp++;
        if ({dout, href, vsync, s_if.tready, underrun, line_err, busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_state: dout/href/vsync/tready/underrun/line_err/busy got %h/%b/%b/%b/%b/%b/%b want all 0",
                     dout, href, vsync, s_if.tready, underrun, line_err, busy);
        end
        do_reset();
    endtask

    task automatic test_normal_frame();
        fill_std();
        run_frame(0, -1, 1'b0);
    endtask

    task automatic test_idle_flush();
        fill_std();
        run_frame(3, -1, 1'b0);
    endtask

    task automatic test_underrun();
        do_reset();
        fill_std();
        frame_px[2].gap = 1'b1;
        run_frame(0, -1, 1'b0);
    endtask

    task automatic test_tlast();
        do_reset();
        fill_std();
        frame_px[1].last = 1'b1;
        run_frame(0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_std();
        run_frame(0, LP * (VS + VB) + LP + 3, 1'b0);
        fill_std();
        run_frame(0, -1, 1'b0);
    endtask

    task automatic test_enable_low();
        do_reset();
        fill_std();
        run_frame(0, -1, 1'b1);
        s_if.tdata  = 16'h1234;
        s_if.tvalid = 1'b1;
        s_if.tuser  = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge pclk);
            n_cmp++;
            if ({s_if.tready, busy, vsync} !== 3'b000) begin
                n_fail++;
                $display("FAIL enable_low_hold: tready/busy/vsync got %b/%b/%b want 0/0/0",
                         s_if.tready, busy, vsync);
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        fill_std();
        run_frame(0, -1, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 5; f++) begin
            fill_random();
            run_frame(int'($urandom_range(0, 2)), -1, 1'b0);
        end
    endtask

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        test_reset();
        test_normal_frame();
        test_idle_flush();
        test_underrun();
        test_tlast();
        test_reset_mid();
        test_enable_low();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
